tnoc_flit_if_sink_target: RTL and testbench
===========================================

# tnoc_flit_if_sink_target

Target-side termination for an unused or debug `tnoc_flit_if` port: accepts every flit offered on every virtual channel and discards it. While discarding, it checks head/tail packet framing per channel and counts completed packets. It sits at any router or fabric boundary where no real consumer exists, on the opposite end from a dummy initiator, so the upstream never stalls and the bench can still observe traffic.

## Interface
- `CONFIG`, default `TNOC_DEFAULT_CONFIG`: fabric configuration.
- `CHANNELS`, default `CONFIG.virtual_channels`: number of virtual channels.
- `PORT_TYPE`, default `TNOC_LOCAL_PORT`: port type. Number of flit lanes `FLITS` is `CHANNELS` when `is_local_port(PORT_TYPE)`, otherwise 1.
- `COUNT_WIDTH`, default 16: width of each packet counter.

- `i_clk`, input, 1: clock. Single clock domain.
- `i_rst_n`, input, 1: reset, asynchronous assert, active-low.
- `flit_if`, `tnoc_flit_if.target`: flit port (valid, ready, vc_available per channel; flit per lane).
- `o_packet_count`, output, `CHANNELS x COUNT_WIDTH`: completed packets per channel.
- `o_framing_error`, output, `CHANNELS`: sticky framing error per channel.
- `o_multi_valid_error`, output, 1: sticky; only meaningful when `FLITS == 1`.

## Operation
- Flit for channel i is `flit[i]` when `FLITS == CHANNELS`, else `flit[0]`. It carries `head` and `tail` fields. A single-flit packet has both set.
- Accept on channel i: `valid[i] && ready[i]` at the rising edge.
- `ready[i]` is 0 in reset and 1 from the first clock edge after reset release, then constant 1.
- `vc_available[i]` follows the same rule as `ready[i]`.
- Per-channel FSM with states IDLE and IN_PACKET:
  - IDLE, accept head && tail: count++, stay IDLE.
  - IDLE, accept head && !tail: go to IN_PACKET.
  - IDLE, accept !head: set framing error, stay IDLE, no count.
  - IN_PACKET, accept !head && tail: count++, go to IDLE.
  - IN_PACKET, accept !head && !tail: stay IN_PACKET.
  - IN_PACKET, accept head: set framing error. The new head restarts the packet: go to IDLE if it also has tail (count++), else stay IN_PACKET. The aborted packet is not counted.
- Channels are fully independent. Simultaneous accepts on different channels each update their own FSM and counter in the same cycle.
- Counters saturate at 2^COUNT_WIDTH−1 and never wrap.
- If `FLITS == 1` and more than one `valid` bit is set in a cycle, set `o_multi_valid_error`. Each valid channel is still processed using the shared `flit[0]`.
- Error flags are sticky until reset.
- Flit payload is ignored and never stored.

## Timing
- Reset values: ready = 0, vc_available = 0, all counts 0, all error flags 0, all FSMs IDLE.
- Reset asserted mid-packet: everything returns to the reset values immediately, asynchronously. A partial packet is lost silently, with no error.
- Counter and flag updates appear one cycle after the accepting edge (registered outputs).
- Zero-bubble throughput: one flit per channel per cycle, sustained.
- A valid flit in the first cycle after reset release is not accepted (ready still 0). The first accept is possible on the second edge after release.

## Test plan
- Single-flit packets: CHANNELS=2, 5 packets (head=tail=1) back-to-back on VC0 → `o_packet_count[0]`=5, `[1]`=0, no errors, ready held 1 throughout.
- Multi-flit packets interleaved: VC0 gets 4-flit packets, VC1 gets 2-flit packets, valids overlapping for 3 packets each → counts 3 and 3. Each count increments exactly one cycle after its tail accept.
- Framing errors:
  - Payload flit (head=0) on idle VC1 → `o_framing_error[1]`=1, count unchanged.
  - New head mid-packet on VC0 → `o_framing_error[0]`=1; completing the new packet gives count +1, not +2.
- Saturation: COUNT_WIDTH=4, 20 single-flit packets → count 15 and holds at 15.
- Non-local port (FLITS=1): valid=2'b11 in one cycle → `o_multi_valid_error`=1 next cycle and stays 1 after valids drop.
- Reset mid-packet: assert `i_rst_n`=0 after 2 flits of a 4-flit packet → outputs go to zero asynchronously. After release, ready rises on the first edge. A fresh full packet then gives count 1 with no framing error.

Source files
------------

// File: rtl/tnoc_flit_if_sink_target.sv
// Flit sink: accepts and discards every flit on every virtual channel.
// Tracks head/tail framing per channel and counts completed packets.
module tnoc_flit_if_sink_target #(
    parameter int unsigned  CHANNELS    = 2,
    parameter bit           LOCAL_PORT  = 1'b1,
    parameter int unsigned  COUNT_WIDTH = 16,
    localparam int unsigned FLITS       = LOCAL_PORT ? CHANNELS : 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [CHANNELS-1:0]                   flit_valid,
    output logic [CHANNELS-1:0]                   flit_ready,
    output logic [CHANNELS-1:0]                   flit_vc_available,
    input  logic [FLITS-1:0]                      flit_head,
    input  logic [FLITS-1:0]                      flit_tail,
    output logic [CHANNELS-1:0][COUNT_WIDTH-1:0]  o_packet_count,
    output logic [CHANNELS-1:0]                   o_framing_error,
    output logic                                  o_multi_valid_error
);

    typedef enum logic {
        IDLE      = 1'b0,
        IN_PACKET = 1'b1
    } state_t;

    logic ready_q;

    // Ready and vc_available rise on the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign flit_ready        = {CHANNELS{ready_q}};
    assign flit_vc_available = {CHANNELS{ready_q}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam int unsigned LANE = (FLITS == CHANNELS) ? i : 0;

        state_t                 state;
        state_t                 state_next;
        logic                   accept;
        logic                   head;
        logic                   tail;
        logic                   count_inc;
        logic                   error_set;
        logic [COUNT_WIDTH-1:0] count_q;
        logic                   error_q;

        assign accept = flit_valid[i] & ready_q;
        assign head   = flit_head[LANE];
        assign tail   = flit_tail[LANE];

        // Framing FSM: a head always restarts the packet, even mid-packet
        always_comb begin
            state_next = state;
            count_inc  = 1'b0;
            error_set  = 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!head) begin
                            error_set = 1'b1;
                        end else if (tail) begin
                            count_inc = 1'b1;
                        end else begin
                            state_next = IN_PACKET;
                        end
                    end
                    IN_PACKET: begin
                        if (head) begin
                            error_set = 1'b1;
                        end
                        if (tail) begin
                            count_inc  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state   <= IDLE;
                count_q <= '0;
                error_q <= 1'b0;
            end else begin
                state <= state_next;
                if (count_inc && (count_q != {COUNT_WIDTH{1'b1}})) begin
                    count_q <= count_q + COUNT_WIDTH'(1);
                end
                if (error_set) begin
                    error_q <= 1'b1;
                end
            end
        end

        assign o_packet_count[i]  = count_q;
        assign o_framing_error[i] = error_q;
    end

    // A shared flit lane cannot carry more than one channel per cycle
    if (FLITS == 1) begin : g_multi
        logic multi_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                multi_q <= 1'b0;
            end else if ($countones(flit_valid) > 1) begin
                multi_q <= 1'b1;
            end
        end

        assign o_multi_valid_error = multi_q;
    end else begin : g_no_multi
        assign o_multi_valid_error = 1'b0;
    end

endmodule

// File: tb/tb_tnoc_flit_if_sink_target.sv
// Scoreboarded bench for the flit sink: three instances (wide counter,
// 4-bit saturating counter, single shared lane) driven by identical stimulus.
module tb_tnoc_flit_if_sink_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  valid = '0;
    logic [1:0]  head = '0;
    logic [1:0]  tail = '0;

    logic [1:0]        rdy_a, vca_a, ferr_a;
    logic [1:0][15:0]  cnt_a;
    logic              mv_a;
    logic [1:0]        rdy_b, vca_b, ferr_b;
    logic [1:0][3:0]   cnt_b;
    logic              mv_b;
    logic [1:0]        rdy_c, vca_c, ferr_c;
    logic [1:0][15:0]  cnt_c;
    logic              mv_c;

    tnoc_flit_if_sink_target #(.CHANNELS(2), .LOCAL_PORT(1'b1), .COUNT_WIDTH(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .flit_valid(valid), .flit_ready(rdy_a),
        .flit_vc_available(vca_a), .flit_head(head), .flit_tail(tail),
        .o_packet_count(cnt_a), .o_framing_error(ferr_a), .o_multi_valid_error(mv_a));

    tnoc_flit_if_sink_target #(.CHANNELS(2), .LOCAL_PORT(1'b1), .COUNT_WIDTH(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .flit_valid(valid), .flit_ready(rdy_b),
        .flit_vc_available(vca_b), .flit_head(head), .flit_tail(tail),
        .o_packet_count(cnt_b), .o_framing_error(ferr_b), .o_multi_valid_error(mv_b));

    tnoc_flit_if_sink_target #(.CHANNELS(2), .LOCAL_PORT(1'b0), .COUNT_WIDTH(16)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .flit_valid(valid), .flit_ready(rdy_c),
        .flit_vc_available(vca_c), .flit_head(head[0]), .flit_tail(tail[0]),
        .o_packet_count(cnt_c), .o_framing_error(ferr_c), .o_multi_valid_error(mv_c));

    always #5 clk = ~clk;

    typedef struct packed {
        logic             rdy;
        logic [5:0][15:0] cnt;
        logic [5:0]       ferr;
        logic [2:0]       mv;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model: packet-level view per instance (k) and channel (ch)
    int   m_cnt[3][2];
    bit   m_inpkt[3][2];
    bit   m_ferr[3][2];
    bit   m_mv[3];
    bit   m_rdy;
    int   m_max[3] = '{65535, 15, 65535};

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t actual();
        exp_t a;
        a.rdy  = &{rdy_a, vca_a, rdy_b, vca_b, rdy_c, vca_c};
        if (!(|{rdy_a, vca_a, rdy_b, vca_b, rdy_c, vca_c})) a.rdy = 1'b0;
        else if (!a.rdy) a.rdy = 1'bx;
        a.cnt  = {cnt_c[1], cnt_c[0], 12'd0, cnt_b[1], 12'd0, cnt_b[0], cnt_a[1], cnt_a[0]};
        a.ferr = {ferr_c, ferr_b, ferr_a};
        a.mv   = {mv_c, mv_b, mv_a};
        return a;
    endfunction

    function automatic exp_t model_snapshot();
        exp_t e;
        e.rdy = m_rdy;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                e.cnt[k*2+ch]  = 16'(m_cnt[k][ch]);
                e.ferr[k*2+ch] = m_ferr[k][ch];
            end
            e.mv[k] = m_mv[k];
        end
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        exp_t a;
        a = actual();
        chk({tag, " ready"}, int'(a.rdy), int'(e.rdy));
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("%s count[%0d]", tag, j), int'(a.cnt[j]), int'(e.cnt[j]));
            chk($sformatf("%s framing[%0d]", tag, j), int'(a.ferr[j]), int'(e.ferr[j]));
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s multi[%0d]", tag, k), int'(a.mv[k]), int'(e.mv[k]));
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_cnt[k][ch]   = 0;
                m_inpkt[k][ch] = 1'b0;
                m_ferr[k][ch]  = 1'b0;
            end
            m_mv[k] = 1'b0;
        end
        m_rdy = 1'b0;
    endfunction

    // Drive one cycle at a falling edge and predict the state after the next rising edge
    task automatic step(input logic [1:0] v, input logic [1:0] h, input logic [1:0] t);
        bit hd, tl;
        valid = v;
        head  = h;
        tail  = t;
        for (int k = 0; k < 3; k++) begin
            if (k == 2 && v == 2'b11) m_mv[k] = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                if (v[ch] && m_rdy) begin
                    hd = (k == 2) ? h[0] : h[ch];
                    tl = (k == 2) ? t[0] : t[ch];
                    if (hd && m_inpkt[k][ch]) m_ferr[k][ch] = 1'b1;
                    if (!hd && !m_inpkt[k][ch]) begin
                        m_ferr[k][ch] = 1'b1;
                    end else if (tl) begin
                        if (m_cnt[k][ch] < m_max[k]) m_cnt[k][ch]++;
                        m_inpkt[k][ch] = 1'b0;
                    end else begin
                        m_inpkt[k][ch] = 1'b1;
                    end
                end
            end
        end
        m_rdy = 1'b1;
        exp_q.push_back(model_snapshot());
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge
    task automatic mid_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset", model_snapshot());
        valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) compare_all("cycle", exp_q.pop_front());
    end

    logic [1:0] rv, rh, rt;

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        compare_all("reset", model_snapshot());
        @(negedge clk);
        rst_n = 1'b1;

        // Flit in the first cycle after release is not accepted
        step(2'b01, 2'b11, 2'b11);
        repeat (5) step(2'b01, 2'b01, 2'b01);

        // Interleaved: VC0 4-flit packets, VC1 2-flit packets
        for (int i = 0; i < 12; i++) begin
            rv = {i < 6 ? 1'b1 : 1'b0, 1'b1};
            rh = {(i % 2) == 0 ? 1'b1 : 1'b0, (i % 4) == 0 ? 1'b1 : 1'b0};
            rt = {(i % 2) == 1 ? 1'b1 : 1'b0, (i % 4) == 3 ? 1'b1 : 1'b0};
            step(rv, rh, rt);
        end

        // Framing errors: payload on idle VC1, new head mid-packet on VC0
        step(2'b10, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b01);

        // Two valids in one cycle on the shared-lane instance
        step(2'b11, 2'b11, 2'b11);
        step(2'b00, 2'b00, 2'b00);

        // Saturation of the 4-bit counter
        repeat (20) step(2'b01, 2'b01, 2'b01);

        // Reset mid-packet, then a clean 4-flit packet
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        mid_reset();
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00);

        // Random traffic, mostly well framed, with one reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) begin
                mid_reset();
            end
            for (int ch = 0; ch < 2; ch++) begin
                rv[ch] = ($urandom_range(0, 3) != 0);
                if (m_inpkt[0][ch]) rh[ch] = ($urandom_range(0, 15) == 0);
                else                rh[ch] = ($urandom_range(0, 15) != 0);
                rt[ch] = $urandom_range(0, 1) == 1;
            end
            step(rv, rh, rt);
        end

        step(2'b00, 2'b00, 2'b00);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
